// File: rtl/rat_io_pkg.sv
// Shared types and constants for the RAT MCU button-interrupt source.
package rat_io_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    PRESSED = 2'd2,
    WAIT_LO = 2'd3
  } db_state_t;

  localparam int unsigned PORT_W          = 8;
  localparam int unsigned EVT_CNT_W       = 8;
  localparam logic [PORT_W-1:0] ACK_PORT_ID_DEF = 8'hFE;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stable-count debounce FSM; strobes o_press_evt_c on
// an accepted press (combinational, asserted in the cycle the FSM enters PRESSED).
module btn_debounce
  import rat_io_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press_evt_c
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam bit DB_ONE = (DB_CYCLES == 1);

  logic [1:0]       r_sync;
  logic             w_btn_s;
  db_state_t        r_state;
  db_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_btn_s = r_sync[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    o_press_evt_c = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_btn_s) begin
          // A single-cycle debounce window accepts the press on first sight.
          if (DB_ONE) begin
            w_state_nxt   = PRESSED;
            w_cnt_nxt     = '0;
            o_press_evt_c = 1'b1;
          end else begin
            w_state_nxt = WAIT_HI;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      WAIT_HI: begin
        if (!w_btn_s) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt   = PRESSED;
          w_cnt_nxt     = '0;
          o_press_evt_c = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!w_btn_s) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (w_btn_s) begin
          w_state_nxt = PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/intr_debounce_gen.sv
// Button interrupt source: debounced press sets a pending level on INTR, an OUT to
// ACK_PORT_ID clears it. Define INTR_CNT_EN to build the missed-press counter EVT_CNT.
module intr_debounce_gen
  import rat_io_pkg::*;
#(
  parameter int unsigned        DB_CYCLES   = 500000,
  parameter logic [PORT_W-1:0]  ACK_PORT_ID = ACK_PORT_ID_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 BTN_IN,
  input  logic                 IO_STRB,
  input  logic [PORT_W-1:0]    PORT_ID,
  input  logic [PORT_W-1:0]    OUT_PORT,
  output logic                 INTR,
  output logic [EVT_CNT_W-1:0] EVT_CNT
);

  logic w_press_evt;
  logic w_ack;
  logic r_pending;
  logic w_unused_out_port;

  // Ack is a write to the ack port; the data value carries no meaning.
  assign w_ack             = IO_STRB && (PORT_ID == ACK_PORT_ID);
  assign w_unused_out_port = ^OUT_PORT;

  btn_debounce #(
    .DB_CYCLES (DB_CYCLES)
  ) u_btn_debounce (
    .i_clk         (CLK),
    .i_rst         (RESET),
    .i_btn         (BTN_IN),
    .o_press_evt_c (w_press_evt)
  );

  // Set has priority over ack so a press landing on the ack cycle is not lost.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pending <= 1'b0;
    end else if (w_press_evt) begin
      r_pending <= 1'b1;
    end else if (w_ack) begin
      r_pending <= 1'b0;
    end
  end

  assign INTR = r_pending;

`ifdef INTR_CNT_EN
  logic [EVT_CNT_W-1:0] r_evt_cnt;

  // Counts presses that arrive while one is already pending; saturating.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_evt_cnt <= '0;
    end else if (w_ack) begin
      r_evt_cnt <= '0;
    end else if (w_press_evt && r_pending && (r_evt_cnt != '1)) begin
      r_evt_cnt <= r_evt_cnt + EVT_CNT_W'(1);
    end
  end

  assign EVT_CNT = r_evt_cnt;
`else
  assign EVT_CNT = '0;
`endif

endmodule

// File: tb/tb_intr_debounce_gen.sv
// Self-checking bench for intr_debounce_gen with DB_CYCLES=4; honours INTR_CNT_EN.
module tb_intr_debounce_gen;

  localparam int unsigned DB = 4;

  logic       CLK;
  logic       RESET;
  logic       BTN_IN;
  logic       IO_STRB;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       INTR;
  logic [7:0] EVT_CNT;

  typedef struct {
    logic       rst;
    logic       btn;
    logic       strb;
    logic [7:0] pid;
    int         n;
    logic       intr;
    logic [7:0] cnt;
    string      nm;
  } vec_t;

  typedef struct {
    logic       intr;
    logic [7:0] cnt;
    string      nm;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  intr_debounce_gen #(
    .DB_CYCLES   (DB),
    .ACK_PORT_ID (8'hFE)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .BTN_IN   (BTN_IN),
    .IO_STRB  (IO_STRB),
    .PORT_ID  (PORT_ID),
    .OUT_PORT (OUT_PORT),
    .INTR     (INTR),
    .EVT_CNT  (EVT_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  function automatic logic [7:0] ecnt(input int n);
`ifdef INTR_CNT_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return (n >= 0) ? 8'h00 : 8'h00;
`endif
  endfunction

  function automatic void add(input logic rst, input logic btn, input logic strb,
                              input logic [7:0] pid, input int n, input logic intr,
                              input string nm);
    vec_t v;
    v.rst = rst; v.btn = btn; v.strb = strb; v.pid = pid; v.n = n;
    v.intr = intr; v.cnt = 8'h00; v.nm = nm;
    tbl.push_back(v);
  endfunction

  // One clock: drive inputs, queue the expectation, sample #1 after the edge.
  task automatic drive(input logic rst, input logic btn, input logic strb,
                       input logic [7:0] pid, input logic ei, input logic [7:0] ec,
                       input string nm);
    exp_t e;
    exp_t got;
    RESET    = rst;
    BTN_IN   = btn;
    IO_STRB  = strb;
    PORT_ID  = pid;
    OUT_PORT = 8'($urandom);
    e.intr = ei; e.cnt = ec; e.nm = nm;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard: queue empty, required one entry", nm);
    end else begin
      got = sb.pop_front();
      if (INTR !== got.intr) begin
        errors++;
        $display("FAIL %s INTR: got %b required %b at %0t", got.nm, INTR, got.intr, $time);
      end
      checks++;
      if (EVT_CNT !== got.cnt) begin
        errors++;
        $display("FAIL %s EVT_CNT: got %02h required %02h at %0t", got.nm, EVT_CNT, got.cnt, $time);
      end
    end
  endtask

  // Full press/release; the press is accepted on the 7th high cycle.
  task automatic press(input logic ib, input logic [7:0] cb, input logic [7:0] ca,
                       input string nm);
    repeat (DB + 2) drive(1'b0, 1'b1, 1'b0, 8'h00, ib, cb, nm);
    repeat (4) drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, ca, nm);
    repeat (9) drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, ca, nm);
  endtask

  initial begin
    RESET = 1'b1; BTN_IN = 1'b0; IO_STRB = 1'b0; PORT_ID = 8'h00; OUT_PORT = 8'h00;

    add(1'b1, 1'b0, 1'b0, 8'h00,  2, 1'b0, "reset");
    add(1'b0, 1'b0, 1'b0, 8'h00,  3, 1'b0, "idle");
    add(1'b0, 1'b1, 1'b0, 8'h00,  6, 1'b0, "clean_wait");
    add(1'b0, 1'b1, 1'b0, 8'h00,  1, 1'b1, "clean_rise");
    add(1'b0, 1'b1, 1'b0, 8'h00, 13, 1'b1, "clean_hold");
    add(1'b0, 1'b1, 1'b1, 8'h10,  1, 1'b1, "ack_other_port");
    add(1'b0, 1'b1, 1'b0, 8'h00,  2, 1'b1, "still_pending");
    add(1'b0, 1'b1, 1'b1, 8'hFE,  1, 1'b0, "ack");
    add(1'b0, 1'b1, 1'b0, 8'h00,  3, 1'b0, "after_ack");
    add(1'b0, 1'b0, 1'b0, 8'h00, 10, 1'b0, "release");
    add(1'b0, 1'b1, 1'b0, 8'h00,  3, 1'b0, "bounce_hi");
    add(1'b0, 1'b0, 1'b0, 8'h00,  1, 1'b0, "bounce_lo");
    add(1'b0, 1'b1, 1'b0, 8'h00,  6, 1'b0, "bounce_final");
    add(1'b0, 1'b1, 1'b0, 8'h00,  5, 1'b1, "bounce_intr");
    add(1'b0, 1'b0, 1'b0, 8'h00, 10, 1'b1, "release_pending");
    add(1'b0, 1'b1, 1'b0, 8'h00,  6, 1'b1, "repress");
    add(1'b0, 1'b1, 1'b1, 8'hFE,  1, 1'b1, "collision");
    add(1'b0, 1'b1, 1'b0, 8'h00,  2, 1'b1, "collision_hold");
    add(1'b0, 1'b1, 1'b1, 8'hFE,  1, 1'b0, "ack_after");
    add(1'b0, 1'b0, 1'b0, 8'h00, 10, 1'b0, "release2");
    add(1'b0, 1'b1, 1'b0, 8'h00,  4, 1'b0, "rst_mid_wait");
    add(1'b1, 1'b1, 1'b0, 8'h00,  1, 1'b0, "rst_in_wait");
    add(1'b0, 1'b1, 1'b0, 8'h00,  6, 1'b0, "full_wait");
    add(1'b0, 1'b1, 1'b0, 8'h00,  2, 1'b1, "full_rise");
    add(1'b1, 1'b1, 1'b0, 8'h00,  1, 1'b0, "rst_pending");
    add(1'b0, 1'b1, 1'b0, 8'h00,  6, 1'b0, "post_rst_wait");
    add(1'b0, 1'b1, 1'b0, 8'h00,  1, 1'b1, "post_rst_rise");
    add(1'b1, 1'b0, 1'b0, 8'h00,  2, 1'b0, "rst_clear");
    add(1'b0, 1'b0, 1'b0, 8'h00,  3, 1'b0, "idle2");

    for (int k = 0; k < tbl.size(); k++) begin
      for (int j = 0; j < tbl[k].n; j++) begin
        drive(tbl[k].rst, tbl[k].btn, tbl[k].strb, tbl[k].pid,
              tbl[k].intr, tbl[k].cnt, tbl[k].nm);
      end
    end

    // Missed-press counting: three presses while pending, then ack.
    press(1'b0, 8'h00, 8'h00, "cnt_first");
    for (int i = 1; i <= 3; i++) press(1'b1, ecnt(i - 1), ecnt(i), "cnt_press");
    drive(1'b0, 1'b0, 1'b1, 8'hFE, 1'b0, 8'h00, "cnt_ack");

    // Saturation after 300 missed presses.
    press(1'b0, 8'h00, 8'h00, "sat_first");
    for (int i = 1; i <= 300; i++) press(1'b1, ecnt(i - 1), ecnt(i), "cnt_sat");
    drive(1'b0, 1'b0, 1'b1, 8'h10, 1'b1, ecnt(300), "cnt_other_port");
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "cnt_reset");
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
